// File: rtl/rvfpm_result_arb.sv
`default_nettype none
// ============================================================================
// Module  : rvfpm_result_arb
// Brief   : Round-robin arbiter sharing the XIF result port between FPU result
//           producers, with a one-entry registered output stage and a
//           counter of results handed to the core.
// Revision: 1.0 - initial release
// ============================================================================
module rvfpm_result_arb #(
    parameter int NUM_SRC    = 2,
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            ck,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC*X_ID_WIDTH-1:0]   src_id,
    input  logic [NUM_SRC*FLEN-1:0]         src_data,
    input  logic [NUM_SRC*5-1:0]            src_rd,
    input  logic [NUM_SRC-1:0]              src_we,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [X_ID_WIDTH-1:0]           result_id,
    output logic [FLEN-1:0]                 result_data,
    output logic [4:0]                      result_rd,
    output logic                            result_we,
    output logic [CNT_WIDTH-1:0]            result_cnt
);

    localparam int         c_ptr_w    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_ptr_w-1:0]    r_rr_ptr;
    logic [c_ptr_w-1:0]    w_grant_idx;
    logic [c_ptr_w-1:0]    w_ptr_nxt;
    logic                  w_grant_vld;
    logic                  w_load_en;
    logic                  w_load;
    logic [X_ID_WIDTH-1:0] r_id;
    logic [FLEN-1:0]       r_data;
    logic [4:0]            r_rd;
    logic                  r_we;
    logic [CNT_WIDTH-1:0]  r_cnt;

    // Ready path is combinational from result_ready so a full stage can be
    // drained and refilled in the same cycle.
    assign w_load_en = (r_state == c_st_empty) || result_ready;
    assign w_load    = w_load_en && w_grant_vld;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin : p_arbiter
        int v_idx;
        v_idx       = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_SRC) begin
                v_idx = v_idx - NUM_SRC;
            end
            if (src_valid[c_ptr_w'(v_idx)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = c_ptr_w'(v_idx);
            end
        end
    end

    assign w_ptr_nxt = (w_grant_idx == c_ptr_w'(NUM_SRC - 1)) ? '0 : w_grant_idx + 1'b1;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_ready
            assign src_ready[i] = w_load && !rst && (w_grant_idx == c_ptr_w'(i));
        end
    endgenerate

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        if (w_load_en) begin
            w_state_nxt = w_grant_vld ? c_st_full : c_st_empty;
        end
    end

    always_ff @(posedge ck or posedge rst) begin : p_state
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ck or posedge rst) begin : p_datapath
        if (rst) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_rd     <= '0;
            r_we     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_load) begin
                r_rr_ptr <= w_ptr_nxt;
                r_id     <= src_id[w_grant_idx*X_ID_WIDTH +: X_ID_WIDTH];
                r_data   <= src_data[w_grant_idx*FLEN +: FLEN];
                r_rd     <= src_rd[w_grant_idx*5 +: 5];
                r_we     <= src_we[w_grant_idx];
            end
            if ((r_state == c_st_full) && result_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign result_valid = (r_state == c_st_full);
    assign result_id    = r_id;
    assign result_data  = r_data;
    assign result_rd    = r_rd;
    assign result_we    = r_we;
    assign result_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rvfpm_result_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_rvfpm_result_arb
// Brief   : Self-checking bench for rvfpm_result_arb against a cycle model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rvfpm_result_arb;

    localparam int N   = 2;
    localparam int IDW = 4;
    localparam int FL  = 32;
    localparam int CW  = 3;

    logic            ck = 1'b0;
    logic            rst;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*IDW-1:0] src_id;
    logic [N*FL-1:0] src_data;
    logic [N*5-1:0]  src_rd;
    logic [N-1:0]    src_we;
    logic            result_valid;
    logic            result_ready;
    logic [IDW-1:0]  result_id;
    logic [FL-1:0]   result_data;
    logic [4:0]      result_rd;
    logic            result_we;
    logic [CW-1:0]   result_cnt;

    rvfpm_result_arb #(
        .NUM_SRC(N), .X_ID_WIDTH(IDW), .FLEN(FL), .CNT_WIDTH(CW)
    ) u_dut (
        .ck(ck), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_id(src_id), .src_data(src_data), .src_rd(src_rd), .src_we(src_we),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_id(result_id), .result_data(result_data),
        .result_rd(result_rd), .result_we(result_we),
        .result_cnt(result_cnt)
    );

    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    // Reference model: pointer, one held entry, handshake count.
    int             m_ptr;
    bit             m_valid;
    logic [IDW-1:0] m_id;
    logic [FL-1:0]  m_data;
    logic [4:0]     m_rd;
    logic           m_we;
    int             m_cnt;
    logic [N-1:0]   m_ready;
    int             grants[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            if (src_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_id = '0; m_data = '0; m_rd = '0; m_we = 1'b0; m_cnt = 0;
    endtask

    task automatic set_src(input int i, input bit v, input logic [IDW-1:0] id,
                           input logic [FL-1:0] d, input logic [4:0] rd, input logic we);
        src_valid[i]         = v;
        src_id[i*IDW +: IDW] = id;
        src_data[i*FL +: FL] = d;
        src_rd[i*5 +: 5]     = rd;
        src_we[i]            = we;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":valid"}, result_valid, m_valid);
        check({tag, ":cnt"}, result_cnt, (m_cnt % (1 << CW)));
        if (m_valid) begin
            check({tag, ":id"},   result_id,   m_id);
            check({tag, ":data"}, result_data, m_data);
            check({tag, ":rd"},   result_rd,   m_rd);
            check({tag, ":we"},   result_we,   m_we);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        int g;
        bit ld;
        #1;
        ld = !m_valid || result_ready;
        g  = ld ? m_grant() : -1;
        m_ready = '0;
        if (g >= 0) m_ready[g] = 1'b1;
        check({tag, ":src_ready"}, src_ready, m_ready);
        @(posedge ck);
        if (m_valid && result_ready) m_cnt++;
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1;
                m_id    = src_id[g*IDW +: IDW];
                m_data  = src_data[g*FL +: FL];
                m_rd    = src_rd[g*5 +: 5];
                m_we    = src_we[g];
                m_ptr   = (g + 1) % N;
                grants.push_back(g);
            end else begin
                m_valid = 0;
            end
        end
        @(negedge ck);
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1;
        src_valid = '0; src_id = '0; src_data = '0; src_rd = '0; src_we = '0;
        result_ready = 1'b0;
        model_reset();
        @(negedge ck);
        @(negedge ck);
        check("reset:src_ready", src_ready, 2'b00);
        check("reset:id", result_id, 4'd0);
        check("reset:data", result_data, 32'd0);
        check("reset:rd", result_rd, 5'd0);
        check("reset:we", result_we, 1'b0);
        check_outputs("reset");
        rst = 1'b0;

        // Single source: src 1 only.
        set_src(1, 1, 4'd3, 32'h3F80_0000, 5'd5, 1'b1);
        result_ready = 1'b1;
        cycle("single");
        set_src(1, 0, 4'd0, 32'd0, 5'd0, 1'b0);
        cycle("single_accept");

        // Both sources valid with ready high: strict alternation, no bubbles.
        grants.delete();
        for (int c = 0; c < 6; c++) begin
            set_src(0, 1, 4'(c), 32'hA000_0000 + 32'(c), 5'(c), 1'b1);
            set_src(1, 1, 4'(c + 8), 32'hB000_0000 + 32'(c), 5'(c + 16), 1'b0);
            cycle("rr");
        end
        check("rr:grant_count", 32'(grants.size()), 32'd6);
        for (int c = 1; c < grants.size(); c++) begin
            check("rr:alternate", 32'(grants[c]), 32'(1 - grants[c-1]));
        end

        // Backpressure: hold an entry with id 7.
        set_src(0, 0, 4'd0, 32'd0, 5'd0, 1'b0);
        set_src(1, 0, 4'd0, 32'd0, 5'd0, 1'b0);
        cycle("drain_pre");
        set_src(0, 1, 4'd7, 32'hDEAD_BEEF, 5'd9, 1'b1);
        set_src(1, 1, 4'd2, 32'h1234_5678, 5'd10, 1'b1);
        cycle("bp_load");
        result_ready = 1'b0;
        for (int c = 0; c < 4; c++) cycle("bp_hold");
        check("bp:held_id", result_id, 4'd7);
        result_ready = 1'b1;
        cycle("bp_release");

        // Drain and idle: pointer must not move on idle cycles.
        set_src(0, 0, 4'd0, 32'd0, 5'd0, 1'b0);
        set_src(1, 0, 4'd0, 32'd0, 5'd0, 1'b0);
        cycle("drain");
        cycle("idle0");
        cycle("idle1");
        set_src(0, 1, 4'd1, 32'h0000_0011, 5'd1, 1'b0);
        set_src(1, 1, 4'd2, 32'h0000_0022, 5'd2, 1'b1);
        cycle("after_idle");

        // Enough handshakes to wrap the 3-bit counter.
        for (int c = 0; c < 10; c++) cycle("wrap");

        // Asynchronous reset while an entry is held.
        result_ready = 1'b0;
        cycle("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midrst:valid", result_valid, 1'b0);
        check("midrst:cnt", result_cnt, 3'd0);
        check("midrst:src_ready", src_ready, 2'b00);
        @(negedge ck);
        rst = 1'b0;
        result_ready = 1'b1;
        cycle("post_rst_first");
        check("post_rst:first_grant_src0", result_id, 4'd1);

        // Randomized traffic.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                set_src(i, ($urandom_range(0, 2) != 0), 4'($urandom), $urandom, 5'($urandom), 1'($urandom));
            end
            result_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
